// File: rtl/i2c_pkg.sv
// Shared types and derived constants for the I2C transaction sequencer.
// Optional combined-format support is controlled by `I2C_SEQ_RESTART_EN.
package i2c_pkg;

  localparam int unsigned LEN_MAX_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ACKCHK,
`ifdef I2C_SEQ_RESTART_EN
    S_REG,
    S_RESTART,
`endif
    S_WRREQ,
    S_RDREQ,
    S_RDWAIT,
    S_STOP,
    S_STOPWAIT
  } seq_state_t;

  typedef struct packed {
    logic [6:0]           addr;
    logic                 rw;
    logic [LEN_MAX_W-1:0] len;
    logic                 reg_en;
    logic [7:0]           reg_byte;
  } i2c_cmd_t;

  // Bus-release guard after STOP: one SCL period plus margin.
  function automatic int unsigned stop_cyc_f(input int unsigned clk_hz, input int unsigned scl_hz);
    return clk_hz / scl_hz + 4;
  endfunction

  // ACK window must be at least one cycle for the timer to expire.
  function automatic int unsigned ack_cyc_f(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int unsigned tmr_w_f(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// Command, write-stream, read-return, status and byte-master signals of the sequencer.
interface i2c_txn_sequencer_if #(parameter int unsigned LEN_W = 4);
  logic             iCmd_Valid;
  logic             oCmd_Ready;
  logic [6:0]       iCmd_Addr;
  logic             iCmd_Rw;
  logic [LEN_W-1:0] iCmd_Len;
  logic             iCmd_RegEn;
  logic [7:0]       iCmd_Reg;
  logic [7:0]       iWr_Data;
  logic             iWr_Valid;
  logic             oWr_Ready;
  logic [7:0]       oRd_Data;
  logic             oRd_Valid;
  logic             oDone;
  logic             oNack;
  logic             oBusy;
  logic             oI2C_Start;
  logic             oI2C_Stop;
  logic             oI2C_Write;
  logic             oI2C_Read;
  logic [7:0]       oTx_Data;
  logic             iTx_Done;
  logic             iTx_Ready;
  logic             iRx_Done;
  logic [7:0]       iRx_Data;

  modport slave (
    input  iCmd_Valid, iCmd_Addr, iCmd_Rw, iCmd_Len, iCmd_RegEn, iCmd_Reg,
           iWr_Data, iWr_Valid, iTx_Done, iTx_Ready, iRx_Done, iRx_Data,
    output oCmd_Ready, oWr_Ready, oRd_Data, oRd_Valid, oDone, oNack, oBusy,
           oI2C_Start, oI2C_Stop, oI2C_Write, oI2C_Read, oTx_Data
  );

  modport master (
    output iCmd_Valid, iCmd_Addr, iCmd_Rw, iCmd_Len, iCmd_RegEn, iCmd_Reg,
           iWr_Data, iWr_Valid, iTx_Done, iTx_Ready, iRx_Done, iRx_Data,
    input  oCmd_Ready, oWr_Ready, oRd_Data, oRd_Valid, oDone, oNack, oBusy,
           oI2C_Start, oI2C_Stop, oI2C_Write, oI2C_Read, oTx_Data
  );
endinterface

// File: rtl/i2c_seq_timer.sv
// Load / count-down / expire timer shared by the ACK window and the STOP guard.
// A load of N makes oExpired rise on the N-th cycle after the load cycle.
module i2c_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iLoad,
  input  logic [CNT_W-1:0] iLoad_Val,
  output logic             oExpired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load has priority, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (iLoad) begin
      cnt_d = (iLoad_Val == '0) ? '0 : iLoad_Val - CNT_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign oExpired = (cnt_q == '0);
endmodule

// File: rtl/i2c_txn_sequencer.sv
// Transaction sequencer in front of the I2C byte master: one command in,
// Start/Write/Read/Stop pulses out, byte by byte.
// `I2C_SEQ_RESTART_EN adds the register-pointer phase and repeated START.
module i2c_txn_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned I2C_FREQ = 100_000,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned ACK_WAIT = 4
) (
  input logic               iClk,
  input logic               iRst_n,
  i2c_txn_sequencer_if.slave bus
);
  localparam int unsigned STOP_CYC = stop_cyc_f(CLK_FREQ, I2C_FREQ);
  localparam int unsigned ACK_CYC  = ack_cyc_f(ACK_WAIT);
  localparam int unsigned TMR_W    = tmr_w_f(STOP_CYC, ACK_CYC);

  seq_state_t state_q, state_d;
  i2c_cmd_t   cmd_q, cmd_d;
  logic [7:0] tx_data_q, tx_data_d, rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d, done_q, done_d;
  logic       nack_q, nack_d, nack_pend_q, nack_pend_d;
  logic       busy_q, busy_d, cmd_ready_q, cmd_ready_d, wr_ready_q, wr_ready_d;
  logic       start_q, start_d, stop_q, stop_d, write_q, write_d, read_q, read_d;
`ifdef I2C_SEQ_RESTART_EN
  logic       restart_pend_q, restart_pend_d;
`endif
  logic             tmr_load, tmr_expired;
  logic [TMR_W-1:0] tmr_val;

  i2c_seq_timer #(.CNT_W(TMR_W)) u_timer (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iLoad     (tmr_load),
    .iLoad_Val (tmr_val),
    .oExpired  (tmr_expired)
  );

  // Sequencer next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    tx_data_d   = tx_data_q;
    rd_data_d   = rd_data_q;
    nack_d      = nack_q;
    nack_pend_d = nack_pend_q;
    busy_d      = busy_q;
    cmd_ready_d = cmd_ready_q;
    wr_ready_d  = wr_ready_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    write_d     = 1'b0;
    read_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
`ifdef I2C_SEQ_RESTART_EN
    restart_pend_d = restart_pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.iCmd_Valid && cmd_ready_q) begin
          cmd_d.addr     = bus.iCmd_Addr;
          cmd_d.rw       = bus.iCmd_Rw;
          cmd_d.len      = LEN_MAX_W'(bus.iCmd_Len[LEN_W-1:0]);
`ifdef I2C_SEQ_RESTART_EN
          cmd_d.reg_en   = bus.iCmd_RegEn;
          cmd_d.reg_byte = bus.iCmd_Reg;
          restart_pend_d = 1'b0;
          tx_data_d      = {bus.iCmd_Addr, bus.iCmd_RegEn ? 1'b0 : bus.iCmd_Rw};
`else
          cmd_d.reg_en   = 1'b0;
          cmd_d.reg_byte = '0;
          tx_data_d      = {bus.iCmd_Addr, bus.iCmd_Rw};
`endif
          start_d     = 1'b1;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          nack_pend_d = 1'b0;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.iTx_Done) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(ACK_CYC);
          state_d  = S_ACKCHK;
        end
      end
      // ACKCHK is reused after every byte; the pending flags pick the next phase.
      S_ACKCHK: begin
        if (bus.iTx_Ready) begin
`ifdef I2C_SEQ_RESTART_EN
          if (cmd_q.reg_en) begin
            cmd_d.reg_en = 1'b0;
            state_d      = S_REG;
          end else if (restart_pend_q) begin
            state_d = S_RESTART;
          end else
`endif
          if (cmd_q.len == 0) begin
            state_d = S_STOP;
          end else if (!cmd_q.rw) begin
            wr_ready_d = 1'b1;
            state_d    = S_WRREQ;
          end else begin
            state_d = S_RDREQ;
          end
        end else if (tmr_expired) begin
          nack_pend_d = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = TMR_W'(STOP_CYC);
          state_d     = S_STOPWAIT;
        end
      end
`ifdef I2C_SEQ_RESTART_EN
      S_REG: begin
        if (bus.iTx_Ready) begin
          tx_data_d      = cmd_q.reg_byte;
          write_d        = 1'b1;
          restart_pend_d = 1'b1;
          state_d        = S_ADDR;
        end
      end
      S_RESTART: begin
        if (bus.iTx_Ready) begin
          tx_data_d      = {cmd_q.addr, cmd_q.rw};
          start_d        = 1'b1;
          restart_pend_d = 1'b0;
          state_d        = S_ADDR;
        end
      end
`endif
      S_WRREQ: begin
        if (wr_ready_q && bus.iWr_Valid) begin
          tx_data_d  = bus.iWr_Data;
          write_d    = 1'b1;
          wr_ready_d = 1'b0;
          cmd_d.len  = cmd_q.len - LEN_MAX_W'(1);
          state_d    = S_ADDR;
        end
      end
      S_RDREQ: begin
        if (bus.iTx_Ready) begin
          read_d  = 1'b1;
          stop_d  = (cmd_q.len == 1);
          state_d = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        if (bus.iRx_Done) begin
          rd_data_d  = bus.iRx_Data;
          rd_valid_d = 1'b1;
          cmd_d.len  = cmd_q.len - LEN_MAX_W'(1);
          if (cmd_q.len == 1) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(STOP_CYC);
            state_d  = S_STOPWAIT;
          end else begin
            state_d = S_RDREQ;
          end
        end
      end
      S_STOP: begin
        if (bus.iTx_Ready) begin
          stop_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(STOP_CYC);
          state_d  = S_STOPWAIT;
        end
      end
      S_STOPWAIT: begin
        if (tmr_expired) begin
          done_d      = 1'b1;
          nack_d      = nack_pend_q;
          busy_d      = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, command and output registers; reset aborts without issuing STOP.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      tx_data_q   <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
      nack_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
`ifdef I2C_SEQ_RESTART_EN
      restart_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      tx_data_q   <= tx_data_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      nack_q      <= nack_d;
      nack_pend_q <= nack_pend_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      write_q     <= write_d;
      read_q      <= read_d;
`ifdef I2C_SEQ_RESTART_EN
      restart_pend_q <= restart_pend_d;
`endif
    end
  end

  assign bus.oCmd_Ready = cmd_ready_q;
  assign bus.oWr_Ready  = wr_ready_q;
  assign bus.oRd_Data   = rd_data_q;
  assign bus.oRd_Valid  = rd_valid_q;
  assign bus.oDone      = done_q;
  assign bus.oNack      = nack_q;
  assign bus.oBusy      = busy_q;
  assign bus.oI2C_Start = start_q;
  assign bus.oI2C_Stop  = stop_q;
  assign bus.oI2C_Write = write_q;
  assign bus.oI2C_Read  = read_q;
  assign bus.oTx_Data   = tx_data_q;
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer with a behavioural byte-master/slave model.
// Honours `I2C_SEQ_RESTART_EN for the combined-format vector.
module tb_i2c_txn_sequencer;
  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned I2C_FREQ = 100;
  localparam int unsigned LEN_W    = 4;
  localparam int unsigned ACK_WAIT = 4;
  localparam int unsigned STOP_CYC = CLK_FREQ / I2C_FREQ + 4;
`ifdef I2C_SEQ_RESTART_EN
  localparam bit RESTART_ON = 1'b1;
`else
  localparam bit RESTART_ON = 1'b0;
`endif

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;

  i2c_txn_sequencer_if #(.LEN_W(LEN_W)) bus ();

  i2c_txn_sequencer #(
    .CLK_FREQ (CLK_FREQ),
    .I2C_FREQ (I2C_FREQ),
    .LEN_W    (LEN_W),
    .ACK_WAIT (ACK_WAIT)
  ) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    logic [3:0]  len;
    logic        reg_en;
    logic [7:0]  reg_b;
    logic [23:0] data;      // byte i at [8*i +: 8]: write stream or slave read data
    logic        exp_nack;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int tdone_cyc = 0;
  int cnt_start = 0, cnt_write = 0, cnt_read = 0, cnt_stop = 0, cnt_rdstop = 0;
  logic hs = 1'b0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] slave_q[$];
  logic [7:0] wq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic bit present(input logic [6:0] a);
    return (a == 7'h50) || (a == 7'h48) || (a == 7'h68);
  endfunction

  always @(posedge iClk) cyc <= cyc + 1;
  always @(posedge iClk) hs <= bus.iWr_Valid && bus.oWr_Ready;

  // Output monitor: pulse counters plus scoreboard for bytes sent and read.
  always @(negedge iClk) begin
    if (iRst_n) begin
      if (bus.oI2C_Start) cnt_start++;
      if (bus.oI2C_Write) cnt_write++;
      if (bus.oI2C_Read)  cnt_read++;
      if (bus.oI2C_Stop)  cnt_stop++;
      if (bus.oI2C_Read && bus.oI2C_Stop) cnt_rdstop++;
      if (bus.oI2C_Start || bus.oI2C_Write) begin
        if (exp_tx.size() > 0) check("tx_byte", bus.oTx_Data, exp_tx.pop_front());
        else begin
          n_checks++;
          $display("FAIL tx_unexpected: got 0x%0h expected no byte", bus.oTx_Data);
        end
      end
      if (bus.oRd_Valid) begin
        if (exp_rd.size() > 0) check("rd_byte", bus.oRd_Data, exp_rd.pop_front());
        else begin
          n_checks++;
          $display("FAIL rd_unexpected: got 0x%0h expected no byte", bus.oRd_Data);
        end
      end
    end
  end

  // Write-stream source.
  initial begin
    bus.iWr_Valid = 1'b0;
    bus.iWr_Data  = 8'h00;
    forever begin
      @(negedge iClk);
      if (hs && wq.size() > 0) void'(wq.pop_front());
      if (wq.size() > 0) begin
        bus.iWr_Valid = 1'b1;
        bus.iWr_Data  = wq[0];
      end else begin
        bus.iWr_Valid = 1'b0;
      end
    end
  end

  // Byte master + slave model: ready while holding, done a few cycles after each pulse.
  initial begin
    bit ab, ack, lst;
    bus.iTx_Done = 1'b0; bus.iTx_Ready = 1'b0; bus.iRx_Done = 1'b0; bus.iRx_Data = 8'h00;
    forever begin
      @(negedge iClk);
      bus.iTx_Done = 1'b0;
      bus.iRx_Done = 1'b0;
      ab = 1'b0;
      if (!iRst_n) begin
        bus.iTx_Ready = 1'b0;
        continue;
      end
      if (bus.oI2C_Start || bus.oI2C_Write) begin
        ack = bus.oI2C_Write || present(bus.oTx_Data[7:1]);
        bus.iTx_Ready = 1'b0;
        for (int k = 0; k < 3; k++) begin @(negedge iClk); if (!iRst_n) ab = 1'b1; end
        if (!ab) begin
          bus.iTx_Done  = 1'b1;
          bus.iTx_Ready = ack;
          tdone_cyc     = cyc;
        end
      end else if (bus.oI2C_Read) begin
        lst = bus.oI2C_Stop;
        bus.iTx_Ready = 1'b0;
        for (int k = 0; k < 4; k++) begin @(negedge iClk); if (!iRst_n) ab = 1'b1; end
        if (!ab) begin
          bus.iRx_Done  = 1'b1;
          bus.iRx_Data  = (slave_q.size() > 0) ? slave_q.pop_front() : 8'hFF;
          bus.iTx_Ready = !lst;
        end
      end else if (bus.oI2C_Stop) begin
        bus.iTx_Ready = 1'b0;
        for (int k = 0; k < 2; k++) begin @(negedge iClk); if (!iRst_n) ab = 1'b1; end
        if (!ab) bus.iTx_Ready = 1'b1;
      end
    end
  end

  task automatic issue_cmd(input vec_t v);
    @(negedge iClk);
    bus.iCmd_Addr  = v.addr;
    bus.iCmd_Rw    = v.rw;
    bus.iCmd_Len   = v.len;
    bus.iCmd_RegEn = v.reg_en;
    bus.iCmd_Reg   = v.reg_b;
    bus.iCmd_Valid = 1'b1;
    @(negedge iClk);
    bus.iCmd_Valid = 1'b0;
    check("busy_after_accept", bus.oBusy, 1);
    check("cmd_ready_busy", bus.oCmd_Ready, 0);
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 5000 && !seen; t++) begin
      @(negedge iClk);
      if (bus.oDone) seen = 1'b1;
    end
    check("done_seen", seen, 1);
  endtask

  task automatic run_txn(input vec_t v);
    int s0, w0, r0, p0, rs0;
    int e_s, e_w, e_r, e_p, e_rs;
    bit ack, use_reg, seen;
    s0 = cnt_start; w0 = cnt_write; r0 = cnt_read; p0 = cnt_stop; rs0 = cnt_rdstop;
    ack     = present(v.addr);
    use_reg = RESTART_ON && v.reg_en;
    if (use_reg) begin
      exp_tx.push_back({v.addr, 1'b0});
      if (ack) begin
        exp_tx.push_back(v.reg_b);
        exp_tx.push_back({v.addr, v.rw});
      end
    end else begin
      exp_tx.push_back({v.addr, v.rw});
    end
    for (int i = 0; i < int'(v.len); i++) begin
      if (ack && !v.rw) begin exp_tx.push_back(v.data[8*i +: 8]); wq.push_back(v.data[8*i +: 8]); end
      if (ack && v.rw)  begin exp_rd.push_back(v.data[8*i +: 8]); slave_q.push_back(v.data[8*i +: 8]); end
    end
    e_s  = (use_reg && ack) ? 2 : 1;
    e_w  = ((ack && !v.rw) ? int'(v.len) : 0) + ((use_reg && ack) ? 1 : 0);
    e_r  = (ack && v.rw) ? int'(v.len) : 0;
    e_p  = ack ? 1 : 0;
    e_rs = (ack && v.rw && v.len != 0) ? 1 : 0;
    issue_cmd(v);
    wait_done(seen);
    if (seen) begin
      check("nack", bus.oNack, v.exp_nack);
      check("busy_at_done", bus.oBusy, 0);
      check("cmd_ready_at_done", bus.oCmd_Ready, 1);
      if (!ack) check("nack_timing", cyc - tdone_cyc, ACK_WAIT + STOP_CYC + 1);
    end
    check("start_pulses", cnt_start - s0, e_s);
    check("write_pulses", cnt_write - w0, e_w);
    check("read_pulses",  cnt_read - r0,  e_r);
    check("stop_pulses",  cnt_stop - p0,  e_p);
    check("read_with_stop", cnt_rdstop - rs0, e_rs);
    check("tx_left", exp_tx.size(), 0);
    check("rd_left", exp_rd.size(), 0);
    @(negedge iClk);
    check("done_one_cycle", bus.oDone, 0);
    exp_tx.delete(); exp_rd.delete(); slave_q.delete(); wq.delete();
  endtask

  vec_t vecs[5];

  initial begin
    bit seen, bad;
    int w0;
    vecs[0] = '{addr:7'h50, rw:1'b0, len:4'd2, reg_en:1'b0, reg_b:8'h00, data:24'h003CA5, exp_nack:1'b0};
    vecs[1] = '{addr:7'h48, rw:1'b1, len:4'd3, reg_en:1'b0, reg_b:8'h00, data:24'h332211, exp_nack:1'b0};
    vecs[2] = '{addr:7'h27, rw:1'b0, len:4'd2, reg_en:1'b0, reg_b:8'h00, data:24'h0055AA, exp_nack:1'b1};
    vecs[3] = '{addr:7'h50, rw:1'b0, len:4'd0, reg_en:1'b0, reg_b:8'h00, data:24'h000000, exp_nack:1'b0};
    vecs[4] = '{addr:7'h68, rw:1'b1, len:4'd1, reg_en:1'b1, reg_b:8'h75, data:24'h0000C3, exp_nack:1'b0};

    bus.iCmd_Valid = 1'b0; bus.iCmd_Addr = '0; bus.iCmd_Rw = 1'b0;
    bus.iCmd_Len = '0; bus.iCmd_RegEn = 1'b0; bus.iCmd_Reg = '0;

    repeat (3) @(negedge iClk);
    check("rst_cmd_ready", bus.oCmd_Ready, 1);
    check("rst_busy", bus.oBusy, 0);
    check("rst_wr_ready", bus.oWr_Ready, 0);
    check("rst_tx_data", bus.oTx_Data, 8'h00);
    check("rst_rd", {bus.oRd_Data, bus.oRd_Valid}, 9'h000);
    check("rst_pulses", {bus.oI2C_Start, bus.oI2C_Stop, bus.oI2C_Write, bus.oI2C_Read, bus.oDone, bus.oNack}, 6'b0);
    iRst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Second write byte withheld for 1000 cycles: no pulse, byte held, still busy.
    exp_tx.push_back(8'hA0); exp_tx.push_back(8'hA5); exp_tx.push_back(8'h3C);
    wq.push_back(8'hA5);
    w0 = cnt_write;
    issue_cmd(vecs[0]);
    seen = 1'b0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge iClk);
      if ((cnt_write - w0) == 1 && bus.oWr_Ready) seen = 1'b1;
    end
    check("gap_wr_ready", seen, 1);
    bad = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge iClk);
      if (bus.oTx_Data !== 8'hA5 || !bus.oBusy || !bus.oWr_Ready) bad = 1'b1;
    end
    check("gap_hold", bad, 0);
    check("gap_no_write", cnt_write - w0, 1);
    wq.push_back(8'h3C);
    wait_done(seen);
    check("gap_nack", bus.oNack, 0);
    check("gap_writes", cnt_write - w0, 2);
    check("gap_tx_left", exp_tx.size(), 0);
    exp_tx.delete(); wq.delete();

    // Reset during the second data byte, then a fresh command is accepted.
    exp_tx.push_back(8'hA0); exp_tx.push_back(8'hA5); exp_tx.push_back(8'h3C);
    wq.push_back(8'hA5); wq.push_back(8'h3C);
    w0 = cnt_write;
    issue_cmd(vecs[0]);
    seen = 1'b0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge iClk);
      if ((cnt_write - w0) == 2) seen = 1'b1;
    end
    check("rst_mid_reached", seen, 1);
    iRst_n = 1'b0;
    #1;
    check("rst_mid_busy", bus.oBusy, 0);
    check("rst_mid_cmd_ready", bus.oCmd_Ready, 1);
    check("rst_mid_tx_data", bus.oTx_Data, 8'h00);
    check("rst_mid_outs", {bus.oWr_Ready, bus.oI2C_Start, bus.oI2C_Stop, bus.oI2C_Write, bus.oI2C_Read, bus.oDone, bus.oNack}, 7'b0);
    exp_tx.delete(); wq.delete(); exp_rd.delete(); slave_q.delete();
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    run_txn(vecs[3]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
